// File: rtl/mux16_scan_serializer_pkg.sv
// Shared types and constants for the 16:1 mux select sequencer.
// Parity beat is enabled by defining MUX16_SCAN_PARITY_EN.
package mux_pkg;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_e;

  function automatic logic [SEL_W-1:0] sel_first(input bit msb_first);
    return msb_first ? SEL_W'(DATA_W - 1) : '0;
  endfunction

  function automatic logic [SEL_W-1:0] sel_last(input bit msb_first);
    return msb_first ? '0 : SEL_W'(DATA_W - 1);
  endfunction

endpackage

// File: rtl/mux16_scan_serializer_if.sv
// Word-in / bit-out handshake bundle for mux16_scan_serializer.
// master drives words and consumes bits; slave is the serializer.
interface mux16_scan_serializer_if
  import mux_pkg::*;
();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_bit;
  logic              out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_bit,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_bit,
    output out_last
  );

endinterface

// File: rtl/mux16_scan_serializer_mux.sv
// 16:1 mux built as a generated tree of 2:1 stages.
// Level l halves the candidates using select[l].
module mux16_1_generate
  import mux_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [SEL_W-1:0]  select,
  output logic              y
);

  for (genvar l = 0; l < SEL_W; l++) begin : g_lvl
    localparam int N = DATA_W >> (l + 1);
    logic [N-1:0] v;
    for (genvar i = 0; i < N; i++) begin : g_node
      if (l == 0) begin : g_leaf
        assign v[i] = select[0] ? in[2*i+1] : in[2*i];
      end else begin : g_inner
        assign v[i] = select[l] ? g_lvl[l-1].v[2*i+1]
                                : g_lvl[l-1].v[2*i];
      end
    end
  end

  assign y = g_lvl[SEL_W-1].v[0];

endmodule

// File: rtl/mux16_scan_serializer.sv
// Holds a 16-bit word and steps the mux select through it, one bit per beat.
// Define MUX16_SCAN_PARITY_EN to append an even-parity beat after the data.
module mux16_scan_serializer
  import mux_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  mux16_scan_serializer_if.slave bus,
  output logic [SEL_W-1:0]     sel,
  output logic                 busy
);

  localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(MSB_FIRST);
  localparam logic [SEL_W-1:0] SEL_LAST  = sel_last(MSB_FIRST);

  state_e            state_q;
  logic [DATA_W-1:0] hold_q;
  logic [SEL_W-1:0]  sel_q;
  logic [SEL_W-1:0]  sel_d;
  logic              beat;
  logic              at_last;
  logic              mux_y;

  assign beat    = bus.out_valid && bus.out_ready;
  assign at_last = (sel_q == SEL_LAST);
  assign sel_d   = MSB_FIRST ? sel_q - 1'b1 : sel_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      sel_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            hold_q  <= bus.in_data;
            sel_q   <= SEL_FIRST;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (beat) begin
            // terminal index is compared, so sel never wraps
            if (at_last) begin
`ifdef MUX16_SCAN_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= IDLE;
`endif
            end else begin
              sel_q <= sel_d;
            end
          end
        end
`ifdef MUX16_SCAN_PARITY_EN
        PARITY: begin
          if (beat) state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  mux16_1_generate u_mux (
    .in     (hold_q),
    .select (sel_q),
    .y      (mux_y)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q != IDLE);
  assign busy          = (state_q != IDLE);
  assign sel           = sel_q;

`ifdef MUX16_SCAN_PARITY_EN
  assign bus.out_bit  = (state_q == PARITY) ? ^hold_q : mux_y;
  assign bus.out_last = (state_q == PARITY);
`else
  assign bus.out_bit  = mux_y;
  assign bus.out_last = (state_q == SHIFT) && at_last;
`endif

endmodule

// File: tb/tb_mux16_scan_serializer.sv
// Bench for mux16_scan_serializer: LSB-first and MSB-first copies driven
// in lockstep and compared beat by beat against a bit-order model.
module tb_mux16_scan_serializer;

  import mux_pkg::*;

`ifdef MUX16_SCAN_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] sel_l, sel_m;
  logic busy_l, busy_m;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mux16_scan_serializer_if if_l ();
  mux16_scan_serializer_if if_m ();

  mux16_scan_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk (clk), .rst (rst), .bus (if_l.slave),
    .sel (sel_l), .busy (busy_l)
  );

  mux16_scan_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk (clk), .rst (rst), .bus (if_m.slave),
    .sel (sel_m), .busy (busy_m)
  );

  // {out_valid, out_bit, out_last, in_ready, busy, sel}
  wire [8:0] obs_l = {if_l.out_valid, if_l.out_bit, if_l.out_last,
                      if_l.in_ready, busy_l, sel_l};
  wire [8:0] obs_m = {if_m.out_valid, if_m.out_bit, if_m.out_last,
                      if_m.in_ready, busy_m, sel_m};

  // Expected observation while beat k of word w is presented.
  function automatic logic [8:0] exp_beat(input logic [15:0] w,
                                          input int k, input bit msb);
    logic b;
    logic [3:0] s;
    if (k >= 16) begin
      b = ^w;
      s = msb ? 4'd0 : 4'd15;
    end else begin
      b = msb ? w[15-k] : w[k];
      s = msb ? 4'(15 - k) : 4'(k);
    end
    return {1'b1, b, (k == NB - 1), 1'b0, 1'b1, s};
  endfunction

  task automatic drive(input logic v, input logic [15:0] d, input logic r);
    if_l.in_valid  = v;
    if_m.in_valid  = v;
    if_l.in_data   = d;
    if_m.in_data   = d;
    if_l.out_ready = r;
    if_m.out_ready = r;
  endtask

  task automatic check_reset_vals(input string tag);
    n_checks++;
    if (obs_l !== 9'b0_0_0_1_0_0000) begin
      $display("FAIL %s lsb: got %b want %b", tag, obs_l, 9'b000100000);
    end else n_pass++;
    n_checks++;
    if (obs_m !== 9'b0_0_0_1_0_0000) begin
      $display("FAIL %s msb: got %b want %b", tag, obs_m, 9'b000100000);
    end else n_pass++;
  endtask

  // Send one word; stall_at/stall_len inject backpressure, intrude_at
  // raises in_valid with ~w while busy, stop_at ends early (for reset).
  task automatic run_word(input logic [15:0] w, input bit rnd,
                          input int stall_at, input int stall_len,
                          input int intrude_at, input int stop_at,
                          output int cycles);
    int k;
    int left;
    bit rdy;
    logic [8:0] el, em;
    k = 0;
    left = stall_len;
    cycles = 0;
    @(negedge clk);
    n_checks++;
    if (obs_l[5] !== 1'b1 || obs_m[5] !== 1'b1) begin
      $display("FAIL accept in_ready: got %b/%b want 1/1",
               obs_l[5], obs_m[5]);
    end else n_pass++;
    drive(1'b1, w, 1'b1);
    while (k < stop_at && cycles < 400) begin
      @(negedge clk);
      el = exp_beat(w, k, 1'b0);
      em = exp_beat(w, k, 1'b1);
      n_checks++;
      if (obs_l !== el) begin
        $display("FAIL lsb w=%h beat %0d: got %b want %b", w, k, obs_l, el);
      end else n_pass++;
      n_checks++;
      if (obs_m !== em) begin
        $display("FAIL msb w=%h beat %0d: got %b want %b", w, k, obs_m, em);
      end else n_pass++;
      if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else if (k == stall_at && left > 0) begin
        rdy = 1'b0;
        left--;
      end else begin
        rdy = 1'b1;
      end
      drive(k == intrude_at, ~w, rdy);
      cycles++;
      if (rdy) k++;
    end
    if (cycles >= 400) begin
      n_checks++;
      $display("FAIL timeout w=%h: got %0d beats want %0d", w, k, stop_at);
    end
    drive(1'b0, 16'h0, 1'b1);
    if (stop_at >= NB) begin
      @(negedge clk);
      n_checks++;
      if ({obs_l[8], obs_l[6:4], obs_m[8], obs_m[6:4]} !== 8'b0010_0010) begin
        $display("FAIL idle after w=%h: got %b/%b want 0010/0010", w,
                 {obs_l[8], obs_l[6:4]}, {obs_m[8], obs_m[6:4]});
      end else n_pass++;
    end
  endtask

  task automatic test_reset;
    drive(1'b0, 16'h0, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");
  endtask

  task automatic test_a5a5;
    int c;
    run_word(16'hA5A5, 1'b0, -1, 0, -1, NB, c);
    n_checks++;
    if (c !== NB) begin
      $display("FAIL a5a5 latency: got %0d cycles want %0d", c, NB);
    end else n_pass++;
  endtask

  task automatic test_backpressure;
    int c;
    run_word(16'h8001, 1'b0, 5, 3, -1, NB, c);
    n_checks++;
    if (c !== NB + 3) begin
      $display("FAIL stall cycles: got %0d want %0d", c, NB + 3);
    end else n_pass++;
  endtask

  task automatic test_busy_reject;
    int c;
    run_word(16'h0000, 1'b0, -1, 0, 4, NB, c);
    // a stray capture would surface as a second word here
    @(negedge clk);
    n_checks++;
    if (busy_l !== 1'b0 || busy_m !== 1'b0) begin
      $display("FAIL busy reject: got %b/%b want 0/0", busy_l, busy_m);
    end else n_pass++;
  endtask

  task automatic test_reset_midword;
    int c;
    run_word(16'h5A3C, 1'b0, -1, 0, -1, 7, c);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 16'hFFFF, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b1);
    check_reset_vals("midword rst");
    run_word(16'h0003, 1'b0, -1, 0, -1, NB, c);
  endtask

  task automatic test_random;
    int c;
    for (int i = 0; i < 12; i++) begin
      run_word(16'($urandom), 1'b1, -1, 0, -1, NB, c);
    end
  endtask

  task automatic test_back_to_back;
    int c;
    run_word(16'h0001, 1'b0, -1, 0, -1, NB, c);
    run_word(16'hA5A5, 1'b0, -1, 0, -1, NB, c);
    run_word(16'hFFFE, 1'b0, -1, 0, -1, NB, c);
  endtask

  initial begin
    drive(1'b0, 16'h0, 1'b1);
    test_reset();
    test_a5a5();
    test_backpressure();
    test_busy_reject();
    test_reset_midword();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
